// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds default widths, the hard-wired zero register index and the
// writeback request payload used by the pipeline WB stage.
package writeback_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
  localparam int unsigned MAX_WAIT_DEFAULT   = 4;

  // x0 is hard-wired to zero; writes to it never reach the port.
  localparam logic [ADDR_WIDTH_DEFAULT-1:0] REG_ZERO = '0;

  // Writeback request payload as produced by the in-order pipeline.
  typedef struct packed {
    logic                          valid;
    logic [ADDR_WIDTH_DEFAULT-1:0] address;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } wbReq_t;

endpackage : writeback_arbiter_pkg

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and the
// multi-cycle mul/div unit. A one-entry hold slot parks the mul/div result;
// a bounded-wait counter forces it through after MAX_WAIT lost cycles.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   wbValid/Address/Data   pipeline writeback request
//   pipeStall         pipeline write not performed; WB must hold
//   mdValid/Address/Data   mul/div result, accepted when mdReady
//   mdReady           hold slot can take a new mul/div result
//   writeRegister/Address/Data   register-file write port
//   pendingValid/Address   held result, for decode hazard stalls
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wbValid,
  input  logic [ADDR_WIDTH-1:0] wbAddress,
  input  logic [DATA_WIDTH-1:0] wbData,
  output logic                  pipeStall,
  input  logic                  mdValid,
  output logic                  mdReady,
  input  logic [ADDR_WIDTH-1:0] mdAddress,
  input  logic [DATA_WIDTH-1:0] mdData,
  output logic                  writeRegister,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  pendingValid,
  output logic [ADDR_WIDTH-1:0] pendingAddress
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] holdAddress;
  logic [DATA_WIDTH-1:0] holdData;
  logic [WAIT_W-1:0]     waitCount;

  logic holdValid;
  logic pipeReq;
  logic forced;
  logic holdGranted;
  logic pipeGranted;
  logic mdAccept;
  logic mdLoad;
  logic cancel;

  assign holdValid = (state == HELD);

  // Grant decision: reset > forced hold > pipe > hold.
  always_comb begin
    pipeReq     = 1'b0;
    forced      = 1'b0;
    holdGranted = 1'b0;
    pipeGranted = 1'b0;
    mdAccept    = 1'b0;
    mdLoad      = 1'b0;
    cancel      = 1'b0;
    if (reset) begin
      pipeReq     = wbValid && (wbAddress != ZERO_ADDR);
      forced      = holdValid && (waitCount >= WAIT_MAX);
      holdGranted = forced || (holdValid && !pipeReq);
      pipeGranted = pipeReq && !forced;
      mdAccept    = mdValid && (!holdValid || holdGranted);
      mdLoad      = mdAccept && (mdAddress != ZERO_ADDR);
      // Pipe overwrote the held destination: the held value is stale.
      cancel      = holdValid && pipeGranted && (wbAddress == holdAddress) && !mdLoad;
    end
  end

  // Write port and handshake outputs, zero latency from the grant.
  always_comb begin
    writeRegister = 1'b0;
    writeAddress  = '0;
    writeData     = '0;
    pipeStall     = 1'b0;
    mdReady       = 1'b0;
    if (reset) begin
      mdReady   = !holdValid || holdGranted;
      pipeStall = pipeReq && forced;
      if (holdGranted) begin
        writeRegister = 1'b1;
        writeAddress  = holdAddress;
        writeData     = holdData;
      end else if (pipeGranted) begin
        writeRegister = 1'b1;
        writeAddress  = wbAddress;
        writeData     = wbData;
      end
    end
  end

  // Hold slot FSM with bounded-wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= EMPTY;
      holdAddress <= '0;
      holdData    <= '0;
      waitCount   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (mdLoad) begin
            state       <= HELD;
            holdAddress <= mdAddress;
            holdData    <= mdData;
            waitCount   <= '0;
          end
        end
        HELD: begin
          if (mdLoad) begin
            holdAddress <= mdAddress;
            holdData    <= mdData;
            waitCount   <= '0;
          end else if (holdGranted || cancel) begin
            state     <= EMPTY;
            waitCount <= '0;
          end else if (waitCount < WAIT_MAX) begin
            waitCount <= waitCount + WAIT_W'(1);
          end
        end
        default: begin
          state     <= EMPTY;
          waitCount <= '0;
        end
      endcase
    end
  end

  assign pendingValid   = holdValid;
  assign pendingAddress = holdAddress;

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: idle drain, starvation bound,
// WAW cancel, x0 filtering, back-to-back refill and reset mid-hold.
module tb_writeback_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic          wbValid;
  logic [AW-1:0] wbAddress;
  logic [DW-1:0] wbData;
  logic          pipeStall;
  logic          mdValid;
  logic          mdReady;
  logic [AW-1:0] mdAddress;
  logic [DW-1:0] mdData;
  logic          writeRegister;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeData;
  logic          pendingValid;
  logic [AW-1:0] pendingAddress;

  int vectors;
  int miscompares;

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wbValid       (wbValid),
    .wbAddress     (wbAddress),
    .wbData        (wbData),
    .pipeStall     (pipeStall),
    .mdValid       (mdValid),
    .mdReady       (mdReady),
    .mdAddress     (mdAddress),
    .mdData        (mdData),
    .writeRegister (writeRegister),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .pendingValid  (pendingValid),
    .pendingAddress(pendingAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Apply inputs just after a posedge; checks follow after a settle delay.
  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    wbValid   = wv;
    wbAddress = wa;
    wbData    = wd;
    mdValid   = mv;
    mdAddress = ma;
    mdData    = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();

    // Reset held low: outputs forced quiet even with requests present.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    chk("rst_wr",     32'(writeRegister),  32'd0);
    chk("rst_stall",  32'(pipeStall),      32'd0);
    chk("rst_mdrdy",  32'(mdReady),        32'd0);
    chk("rst_pend",   32'(pendingValid),   32'd0);
    chk("rst_paddr",  32'(pendingAddress), 32'd0);
    tick();
    reset = 1'b1;

    // Idle md: accept, write next cycle, pending clears after.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
    chk("idle_mdrdy", 32'(mdReady),       32'd1);
    chk("idle_nowr",  32'(writeRegister), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("idle_pend",  32'(pendingValid),   32'd1);
    chk("idle_paddr", 32'(pendingAddress), 32'd7);
    chk("idle_wr",    32'(writeRegister),  32'd1);
    chk("idle_waddr", 32'(writeAddress),   32'd7);
    chk("idle_wdata", writeData,           32'hDEADBEEF);
    tick();
    chk("idle_pend0", 32'(pendingValid),   32'd0);
    chk("idle_wr0",   32'(writeRegister),  32'd0);

    // Starvation: hold x9, pipe hammers x3; hold forced on 5th cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("starve_waddr", 32'(writeAddress), 32'd3);
      chk("starve_stall", 32'(pipeStall),    32'd0);
      chk("starve_mdrdy", 32'(mdReady),      32'd0);
      tick();
    end
    chk("force_waddr", 32'(writeAddress), 32'd9);
    chk("force_wdata", writeData,         32'h55);
    chk("force_stall", 32'(pipeStall),    32'd1);
    chk("force_mdrdy", 32'(mdReady),      32'd1);
    tick();
    chk("after_waddr", 32'(writeAddress), 32'd3);
    chk("after_wdata", writeData,         32'h33);
    chk("after_stall", 32'(pipeStall),    32'd0);
    chk("after_pend",  32'(pendingValid), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // WAW cancel: pipe writes x5 while x5 is held; held value dropped.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11);
    tick();
    drive(1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'h0);
    chk("waw_waddr", 32'(writeAddress), 32'd5);
    chk("waw_wdata", writeData,         32'h22);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("waw_pend",  32'(pendingValid),  32'd0);
    chk("waw_nowr",  32'(writeRegister), 32'd0);
    tick();

    // x0 pipe write ignored: hold x4 drains immediately, no stall.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
    tick();
    drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
    chk("x0_waddr", 32'(writeAddress), 32'd4);
    chk("x0_wdata", writeData,         32'h44);
    chk("x0_stall", 32'(pipeStall),    32'd0);
    tick();
    // mdAddress x0: accepted and dropped.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
    chk("mdx0_rdy",  32'(mdReady),       32'd1);
    chk("mdx0_nowr", 32'(writeRegister), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("mdx0_wr",   32'(writeRegister), 32'd0);
    chk("mdx0_pend", 32'(pendingValid),  32'd0);
    tick();

    // Back-to-back: drain x2 while accepting x6 in the same cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h20);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    chk("b2b_waddr", 32'(writeAddress), 32'd2);
    chk("b2b_mdrdy", 32'(mdReady),      32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("b2b_paddr", 32'(pendingAddress), 32'd6);
    chk("b2b_waddr2", 32'(writeAddress),  32'd6);
    chk("b2b_wdata2", writeData,          32'h66);
    tick();
    chk("b2b_pend0", 32'(pendingValid), 32'd0);

    // Reset mid-hold: x8 held with waitCount=2, then discarded.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88);
    tick();
    drive(1'b1, 5'd1, 32'h10, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk("rmid_pend", 32'(pendingValid), 32'd1);
    reset = 1'b0;
    #1;
    chk("rmid_wr",    32'(writeRegister), 32'd0);
    chk("rmid_stall", 32'(pipeStall),     32'd0);
    chk("rmid_mdrdy", 32'(mdReady),       32'd0);
    tick();
    chk("rmid_pend0", 32'(pendingValid),   32'd0);
    chk("rmid_paddr", 32'(pendingAddress), 32'd0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("rmid_nowr",  32'(writeRegister), 32'd0);
    tick();
    chk("rmid_nowr2", 32'(writeRegister), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_writeback_arbiter

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle mul/div unit. A one-entry holding register parks the mul/div result until the port is free. A bounded-wait counter stops the pipeline from starving that result. The block also exports the pending destination so decode can stall on RAW/WAW hazards against it.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
MAX_WAIT, 4, max consecutive cycles a held result may lose arbitration before being forced (>=1)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-low; sampled on posedge clk only
wbValid  input  1  pipeline writeback request this cycle
wbAddress  input  ADDR_WIDTH  pipeline destination register
wbData  input  DATA_WIDTH  pipeline writeback data
pipeStall  output  1  pipeline write not performed this cycle; WB stage must hold its request
mdValid  input  1  mul/div result available
mdReady  output  1  arbiter accepts mul/div result this cycle
mdAddress  input  ADDR_WIDTH  mul/div destination register
mdData  input  DATA_WIDTH  mul/div result
writeRegister  output  1  register-file write enable
writeAddress  output  ADDR_WIDTH  register-file write address
writeData  output  DATA_WIDTH  register-file write data
pendingValid  output  1  a held mul/div result is waiting
pendingAddress  output  ADDR_WIDTH  destination of held result

Behaviour:
- State: holdValid, holdAddress, holdData, waitCount (width $clog2(MAX_WAIT+1)). FSM: EMPTY (holdValid=0), HELD (holdValid=1).
- Reset (reset==0 at posedge): holdValid=0, waitCount=0, holdAddress/holdData=0. While reset is low, force writeRegister=0, pipeStall=0, mdReady=0. With state cleared, pendingValid=0 and pendingAddress=0. Reset mid-hold discards the held result.
- Effective requests: pipeReq = wbValid && wbAddress!=0. holdReq = holdValid. x0 pipeline writes never use the port and never stall.
- Grant (combinational):
  - forced = holdReq && waitCount>=MAX_WAIT.
  - If forced: hold wins; pipeStall = pipeReq.
  - Else if pipeReq: pipe wins.
  - Else if holdReq: hold wins.
  - Else: writeRegister=0.
- Write port: drives the winner's address and data with writeRegister=1. Same cycle as grant, zero latency. The register file's write-through bypass covers same-cycle reads.
- mdReady = !holdValid || holdGranted (drain and refill in the same cycle is allowed).
- md accept (mdValid && mdReady):
  - mdAddress==0: accepted and dropped; no hold.
  - Otherwise: holdAddress/holdData loaded next cycle, holdValid=1, waitCount=0.
- Mul/div latency to the port is at least 1 cycle; no combinational md-to-port bypass.
- WAW cancel: pipe granted with wbAddress==holdAddress while HELD and not forced → the held entry is older, so it is dropped (holdValid=0, waitCount=0) in that cycle. This fires only if no new md accept targets that slot in the same cycle. If a new accept does, the new entry loads normally.
- waitCount: increments (saturating at MAX_WAIT) each cycle holdValid && !holdGranted && !cancelled. Clears on drain, cancel, or load.
- Priority per cycle: reset > forced hold > pipe > hold.
- pendingValid=holdValid, pendingAddress=holdAddress, both registered state.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, REG_ZERO constant, and a wbReq struct {valid, address, data} reused by the pipeline WB stage.
- No sub-module; the hold slot plus counter stays inline in a single file.

Test Plan:
- Idle md: mdValid=1, mdAddress=7, mdData=0xDEADBEEF, no wbValid → mdReady=1; next cycle writeRegister=1, writeAddress=7, writeData=0xDEADBEEF; pendingValid drops the following cycle.
- Starvation, MAX_WAIT=4: hold x9=0x55, wbValid=1 every cycle to x3 → pipe wins 4 cycles; 5th cycle writes x9, pipeStall=1, x3 written the cycle after.
- WAW cancel: hold x5=0x11, pipe writes x5=0x22 → port writes 0x22, pendingValid=0 next cycle, x5 never receives 0x11.
- x0 filtering: wbValid=1, wbAddress=0 with hold x4 → hold drains immediately, pipeStall=0. mdAddress=0 accepted with no write.
- Back-to-back md: hold drains while mdValid presents x6 → mdReady=1 same cycle, x6 held next cycle, no bubble.
- Reset mid-hold: HELD x8, waitCount=2, reset=0 for one posedge → pendingValid=0, writeRegister=0 while low; x8 never written after release.
